// File: rtl/prio_encoder_ctrl.sv
// Sequencer/arbiter above a bank of prio_support channels: broadcasts init/setup,
// then grants the lowest-index channel with data and issues {index, addr} reads.
module prio_encoder_ctrl #(
   parameter int NCH          = 8,
   parameter int CW           = 3,
   parameter int AW           = 6,
   parameter int SETUP_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [NCH-1:0]    has_dat,
   input  logic [NCH*AW-1:0] addr_in,
   output logic              init,
   output logic              setup,
   output logic [NCH-1:0]    sel,
   output logic [CW+AW-1:0]  rd_addr,
   output logic              rd_en,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_SETUP = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int CNTW = ($clog2(SETUP_CYCLES) > 0) ? $clog2(SETUP_CYCLES) : 1;
   // INIT already accounts for one setup cycle, so SETUP runs SETUP_CYCLES-1 cycles.
   localparam logic [CNTW-1:0] SETUP_LOAD = CNTW'(SETUP_CYCLES - 2);

   logic [2:0]        state_reg, state_next;
   logic [CNTW-1:0]   cnt_reg, cnt_next;
   logic              zero_reg, zero_next;
   logic              init_reg, init_next;
   logic              setup_reg, setup_next;
   logic [NCH-1:0]    sel_reg, sel_next;
   logic [CW+AW-1:0]  rd_addr_reg, rd_addr_next;
   logic              rd_en_reg, rd_en_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;

   logic [AW-1:0]     addr_arr [NCH];
   logic [NCH-1:0]    grant;
   logic [CW-1:0]     sel_idx;
   logic [AW-1:0]     sel_addr;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_unpack
         assign addr_arr[gi] = addr_in[gi*AW +: AW];
      end
   endgenerate

   // Two's-complement trick isolates the lowest set bit: strict fixed priority.
   assign grant = has_dat & (~has_dat + NCH'(1));

   always_comb begin
      sel_idx  = '0;
      sel_addr = '0;
      for (int i = 0; i < NCH; i++) begin
         if (sel_reg[i]) begin
            sel_idx  = sel_idx | CW'(i);
            sel_addr = sel_addr | addr_arr[i];
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      zero_next    = zero_reg;
      init_next    = 1'b0;
      setup_next   = setup_reg;
      sel_next     = sel_reg;
      rd_addr_next = rd_addr_reg;
      rd_en_next   = 1'b0;
      busy_next    = busy_reg;
      done_next    = 1'b0;
      case (state_reg)
         S_IDLE: begin
            sel_next = '0;
            if (start) begin
               state_next = S_INIT;
               init_next  = 1'b1;
               setup_next = 1'b1;
               busy_next  = 1'b1;
            end
         end
         S_INIT: begin
            state_next = S_SETUP;
            setup_next = 1'b1;
            cnt_next   = SETUP_LOAD;
         end
         S_SETUP: begin
            if (cnt_reg == '0) begin
               state_next = S_RUN;
               setup_next = 1'b0;
               zero_next  = 1'b0;
            end else begin
               cnt_next = cnt_reg - CNTW'(1);
            end
         end
         S_RUN: begin
            sel_next   = grant;
            rd_en_next = |(sel_reg & has_dat);
            if (rd_en_next) begin
               rd_addr_next = {sel_idx, sel_addr};
            end
            if (has_dat == '0) begin
               zero_next = 1'b1;
               if (zero_reg) begin
                  state_next = S_DONE;
                  done_next  = 1'b1;
                  sel_next   = '0;
                  rd_en_next = 1'b0;
               end
            end else begin
               zero_next = 1'b0;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
            busy_next  = 1'b0;
            sel_next   = '0;
         end
         default: begin
            state_next = S_IDLE;
            setup_next = 1'b0;
            busy_next  = 1'b0;
            sel_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= '0;
         zero_reg    <= 1'b0;
         init_reg    <= 1'b0;
         setup_reg   <= 1'b0;
         sel_reg     <= '0;
         rd_addr_reg <= '0;
         rd_en_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         zero_reg    <= zero_next;
         init_reg    <= init_next;
         setup_reg   <= setup_next;
         sel_reg     <= sel_next;
         rd_addr_reg <= rd_addr_next;
         rd_en_reg   <= rd_en_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
      end
   end

   assign init    = init_reg;
   assign setup   = setup_reg;
   assign sel     = sel_reg;
   assign rd_addr = rd_addr_reg;
   assign rd_en   = rd_en_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;

endmodule

// File: tb/tb_prio_encoder_ctrl.sv
// Bench for prio_encoder_ctrl: behavioural prio_support channels, read-address
// scoreboard fed by the stimulus, and directed timing checks.
module tb_prio_encoder_ctrl;

   localparam int NCH = 8;
   localparam int CW  = 3;
   localparam int AW  = 6;
   localparam int SC  = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [NCH-1:0]    has_dat = '0;
   logic [NCH*AW-1:0] addr_in;
   logic              init, setup, rd_en, busy, done;
   logic [NCH-1:0]    sel;
   logic [CW+AW-1:0]  rd_addr;

   int checks = 0;
   int errors = 0;
   int rd_cnt = 0;
   logic [CW+AW-1:0] exp_q[$];

   int ld   [NCH];
   int cnt  [NCH];
   int addr [NCH];

   prio_encoder_ctrl #(.NCH(NCH), .CW(CW), .AW(AW), .SETUP_CYCLES(SC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .has_dat(has_dat), .addr_in(addr_in),
      .init(init), .setup(setup), .sel(sel), .rd_addr(rd_addr), .rd_en(rd_en),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < NCH; i++) begin
         ld[i] = 0; cnt[i] = 0; addr[i] = 0;
      end
   end

   // prio_support model: load on init, count down/address up on each granted read.
   always @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (init) begin
            cnt[i]     <= ld[i];
            addr[i]    <= 0;
            has_dat[i] <= (ld[i] != 0);
         end else if (sel[i] && has_dat[i]) begin
            cnt[i]     <= cnt[i] - 1;
            addr[i]    <= addr[i] + 1;
            has_dat[i] <= (cnt[i] != 1);
         end
      end
   end

   always_comb begin
      addr_in = '0;
      for (int i = 0; i < NCH; i++) addr_in[i*AW +: AW] = AW'(addr[i]);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // Scoreboard monitor: every read the DUT issues must match the next queued address.
   always @(negedge clk) begin
      if (rst_n && rd_en) begin
         rd_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got rd_addr 0x%0h, expected no read", rd_addr);
         end else begin
            chk("rd_addr", rd_addr, exp_q.pop_front());
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_loads();
      for (int i = 0; i < NCH; i++) ld[i] = 0;
   endtask

   task automatic push_reads(input int ch, input int n);
      logic [CW+AW-1:0] a;
      for (int k = 0; k < n; k++) begin
         a = {CW'(ch), AW'(k)};
         exp_q.push_back(a);
      end
   endtask

   // Pulse start across one rising edge; returns at the negedge after it.
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cycles, output int zc);
      bit seen;
      cycles = 0; zc = 0; seen = 0;
      while (!seen && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (done) seen = 1;
         else if (has_dat == '0) zc++;
         else zc = 0;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done in %0d cycles, expected a done pulse", budget);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_init"},    init,    0);
      chk({tag, "_setup"},   setup,   0);
      chk({tag, "_sel"},     sel,     0);
      chk({tag, "_rd_en"},   rd_en,   0);
      chk({tag, "_busy"},    busy,    0);
      chk({tag, "_done"},    done,    0);
   endtask

   initial begin
      int cyc, zc;
      rst_n = 1'b0;
      start = 1'b0;
      step(2);
      rst_n = 1'b1;

      // 1a: idle after reset release
      step(10);
      check_idle_outputs("reset");
      chk("reset_rd_addr", rd_addr, 0);

      // 2+3: channels 0,2,5 with 2,1,3 items; init/setup/sel timing
      clear_loads();
      ld[0] = 2; ld[2] = 1; ld[5] = 3;
      push_reads(0, 2); push_reads(2, 1); push_reads(5, 3);
      rd_cnt = 0;
      pulse_start();
      chk("t2_init_hi", init, 1); chk("t2_setup_c1", setup, 1); chk("t2_busy", busy, 1);
      step(1); chk("t2_init_lo", init, 0); chk("t2_setup_c2", setup, 1);
      step(1); chk("t2_setup_c3", setup, 1); chk("t2_sel_pre", sel, 0);
      step(1); chk("t2_setup_off", setup, 0); chk("t2_sel_run0", sel, 0);
      step(1); chk("t2_sel_first", sel, 8'h01);
      wait_done(100, cyc, zc);
      chk("t3_done_lag", zc, 2);
      chk("t3_done_busy", busy, 1);
      step(1);
      chk("t3_busy_after", busy, 0); chk("t3_done_pulse", done, 0);
      chk("t3_rd_count", rd_cnt, 6);
      chk("t3_queue_empty", exp_q.size(), 0);
      chk("t3_rd_addr_hold", rd_addr, 9'h142);

      // 4: all channels empty
      clear_loads();
      rd_cnt = 0;
      pulse_start();
      wait_done(50, cyc, zc);
      chk("t4_done_lat", cyc, 5);
      chk("t4_busy_in_done", busy, 1);
      step(1);
      chk("t4_busy_fall", busy, 0);
      chk("t4_rd_count", rd_cnt, 0);

      // 1b: asynchronous reset mid-RUN
      clear_loads();
      ld[4] = 5;
      push_reads(4, 5);
      pulse_start();
      step(6);
      chk("t1b_sel_run", sel, 8'h10);
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("midrst");
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step(2);
      chk("t1b_idle_busy", busy, 0);

      // 5: start ignored during RUN and DONE, then honoured in IDLE
      clear_loads();
      ld[3] = 4;
      push_reads(3, 4);
      rd_cnt = 0;
      pulse_start();
      step(5);
      pulse_start();
      chk("t5_run_no_init", init, 0); chk("t5_run_busy", busy, 1); chk("t5_run_setup", setup, 0);
      wait_done(100, cyc, zc);
      pulse_start();
      chk("t5_done_no_init", init, 0); chk("t5_done_to_idle", busy, 0);
      step(2);
      chk("t5_still_idle", busy, 0);
      chk("t5_rd_count", rd_cnt, 4);
      clear_loads();
      ld[1] = 1;
      push_reads(1, 1);
      pulse_start();
      chk("t5_restart_init", init, 1);
      step(1); chk("t5_restart_setup", setup, 1);
      step(3); chk("t5_restart_sel", sel, 8'h02);
      wait_done(100, cyc, zc);
      step(1);
      chk("t5_queue_empty", exp_q.size(), 0);

      // 6: channel 0 (1 item) beats channel 7 (63 items)
      clear_loads();
      ld[0] = 1; ld[7] = 63;
      push_reads(0, 1); push_reads(7, 63);
      rd_cnt = 0;
      pulse_start();
      step(4);
      chk("t6_sel_ch0", sel, 8'h01);
      step(2);
      chk("t6_sel_ch7", sel, 8'h80);
      wait_done(200, cyc, zc);
      step(1);
      chk("t6_rd_count", rd_cnt, 64);
      chk("t6_last_addr", rd_addr, 9'h1FE);
      chk("t6_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
